// File: rtl/uart_mat_ctrl_pkg.sv
// Shared types and sizing helpers for the UART/matrix-multiplier frame controller.
package uart_mat_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX       = 3'd1,
        ST_MM_START = 3'd2,
        ST_MM_WAIT  = 3'd3,
        ST_TX_REQ   = 3'd4,
        ST_TX_ACK   = 3'd5
    } state_t;

    // Bytes in an input frame (A then B).
    function automatic int unsigned nb_in(input int unsigned n);
        return 2 * n * n;
    endfunction

    // Bytes in the result stream (C, LSB first per element).
    function automatic int unsigned nb_out(input int unsigned n, input int unsigned rw);
        return (n * n * rw) / 8;
    endfunction

endpackage

// File: rtl/uart_mat_ctrl_sync_edge.sv
// Two-flop synchroniser plus an edge register; edges are taken on the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level  = s2_q;
    assign rise_c = s2_q & ~s3_q;
    assign fall_c = ~s2_q & s3_q;

endmodule

// File: rtl/uart_mat_ctrl.sv
// Collects A and B from the UART, starts the multiplier, then streams C back byte by byte.
module uart_mat_ctrl
    import uart_mat_ctrl_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned RW      = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_status,
    input  logic [7:0]        rx_byte,
    output logic              tx_ready,
    output logic [7:0]        tx_byte,
    input  logic              tx_status,
    output logic              mm_start,
    input  logic              mm_done,
    output logic [N*N*8-1:0]  mat_a,
    output logic [N*N*8-1:0]  mat_b,
    input  logic [N*N*RW-1:0] mat_c,
    output logic              busy,
    output logic              err
);

    localparam int unsigned NN     = N * N;
    localparam int unsigned NB_IN  = nb_in(N);
    localparam int unsigned NB_OUT = nb_out(N, RW);
    localparam int unsigned RX_W   = $clog2(NB_IN);
    localparam int unsigned TX_W   = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    state_t                       state_q, state_d;
    logic [RX_W-1:0]              rx_idx_q, rx_idx_d;
    logic [TX_W-1:0]              tx_idx_q, tx_idx_d;
    logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
    logic [NB_IN-1:0][7:0]        op_q, op_d;
    logic [NB_OUT-1:0][7:0]       res_q, res_d;
    logic [7:0]                   tx_byte_d;
    logic                         err_d;

    logic rx_level, rx_rise, rx_fall;
    logic tx_level, tx_rise, tx_fall;

    sync_edge u_rx_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (rx_status),
        .level  (rx_level),
        .rise_c (rx_rise),
        .fall_c (rx_fall)
    );

    sync_edge u_tx_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (tx_status),
        .level  (tx_level),
        .rise_c (tx_rise),
        .fall_c (tx_fall)
    );

    logic unused_sync;
    assign unused_sync = rx_level ^ rx_rise ^ tx_rise ^ tx_fall;

    // Next-state and datapath; a captured byte beats a coincident timeout.
    always_comb begin
        state_d   = state_q;
        rx_idx_d  = rx_idx_q;
        tx_idx_d  = tx_idx_q;
        to_cnt_d  = to_cnt_q;
        op_d      = op_q;
        res_d     = res_q;
        err_d     = 1'b0;
        tx_byte_d = tx_byte;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    op_d[0]  = rx_byte;
                    rx_idx_d = RX_W'(1);
                    to_cnt_d = '0;
                    state_d  = ST_RX;
                end
            end
            ST_RX: begin
                if (rx_fall) begin
                    op_d[rx_idx_q] = rx_byte;
                    to_cnt_d       = '0;
                    if (rx_idx_q == RX_W'(NB_IN - 1)) begin
                        rx_idx_d = '0;
                        state_d  = ST_MM_START;
                    end else begin
                        rx_idx_d = rx_idx_q + RX_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    rx_idx_d = '0;
                    to_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_MM_START: state_d = ST_MM_WAIT;
            ST_MM_WAIT: begin
                if (mm_done) begin
                    res_d    = mat_c;
                    tx_idx_d = '0;
                    state_d  = ST_TX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (tx_level) state_d = ST_TX_ACK;
            end
            ST_TX_ACK: begin
                if (!tx_level) begin
                    if (tx_idx_q == TX_W'(NB_OUT - 1)) begin
                        tx_idx_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + TX_W'(1);
                        state_d  = ST_TX_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_TX_REQ) tx_byte_d = res_d[tx_idx_d];
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rx_idx_q <= '0;
            tx_idx_q <= '0;
            to_cnt_q <= '0;
            op_q     <= '0;
            res_q    <= '0;
            tx_ready <= 1'b0;
            tx_byte  <= '0;
            mm_start <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_idx_q <= rx_idx_d;
            tx_idx_q <= tx_idx_d;
            to_cnt_q <= to_cnt_d;
            op_q     <= op_d;
            res_q    <= res_d;
            tx_ready <= (state_d == ST_TX_REQ);
            tx_byte  <= tx_byte_d;
            mm_start <= (state_d == ST_MM_START);
            busy     <= (state_d != ST_IDLE);
            err      <= err_d;
        end
    end

    assign mat_a = op_q[NN-1:0];
    assign mat_b = op_q[NB_IN-1:NN];

endmodule
